game_flow_controller: RTL and testbench

Top-level game sequencer. It steps the game through TITLE, SERVE, PLAY, LIFE_LOST and GAME_OVER, and owns the lives and wave counters. It drives freeze and reset strobes to the object and paddle logic, and selects which overlay the pixel mux shows (title or game-over). All timing is counted in frames using the fsync pulse.

---
 rtl/game_flow_controller_pkg.sv | 21 ++
 rtl/game_flow_controller_frame_timer.sv | 28 ++
 rtl/game_flow_controller.sv | 144 ++++++++++++++
 tb/tb_game_flow_controller.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_flow_controller_pkg.sv
// Shared types and default timing constants for the game flow controller.
package game_flow_controller_pkg;

    typedef enum logic [2:0] {
        TITLE     = 3'd0,
        SERVE     = 3'd1,
        PLAY      = 3'd2,
        LIFE_LOST = 3'd3,
        GAME_OVER = 3'd4
    } game_state_t;

    localparam int unsigned STATE_W         = 3;
    localparam int unsigned LIVES_W         = 4;
    localparam int unsigned WAVE_W          = 8;

    localparam int unsigned LIVES_INIT       = 3;
    localparam int unsigned SERVE_FRAMES     = 60;
    localparam int unsigned LIFE_LOST_FRAMES = 90;
    localparam int unsigned GAMEOVER_FRAMES  = 180;

endpackage

// File: rtl/game_flow_controller_frame_timer.sv
// Frame counter shared by the timed states; done_c fires on the n-th counted fsync.
module game_flow_controller_frame_timer #(
    parameter int unsigned TIMER_W = 8
) (
    input  logic             pixel_clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             fsync,
    input  logic [TIMER_W:0] n,
    output logic             done_c
);

    localparam int unsigned CNT_W = TIMER_W + 1;

    logic [TIMER_W-1:0] timer_q;

    // clear marks the state-entry cycle, so an fsync there is discarded
    always_ff @(posedge pixel_clk) begin
        if (rst || clear) begin
            timer_q <= '0;
        end else if (fsync) begin
            timer_q <= timer_q + TIMER_W'(1);
        end
    end

    assign done_c = fsync && !clear && ({1'b0, timer_q} == (n - CNT_W'(1)));

endmodule

// File: rtl/game_flow_controller.sv
// Top-level game sequencer: state machine, lives/wave counters and overlay/strobe outputs.
module game_flow_controller #(
    parameter int unsigned LIVES_INIT       = game_flow_controller_pkg::LIVES_INIT,
    parameter int unsigned SERVE_FRAMES     = game_flow_controller_pkg::SERVE_FRAMES,
    parameter int unsigned LIFE_LOST_FRAMES = game_flow_controller_pkg::LIFE_LOST_FRAMES,
    parameter int unsigned GAMEOVER_FRAMES  = game_flow_controller_pkg::GAMEOVER_FRAMES,
    parameter int unsigned TIMER_W          = 8
) (
    input  logic       pixel_clk,
    input  logic       rst,
    input  logic       fsync,
    input  logic       start_btn,
    input  logic       ball_lost,
    input  logic       wave_clear,
    output logic [2:0] state,
    output logic [3:0] lives,
    output logic [7:0] wave,
    output logic       freeze,
    output logic       rst_objects,
    output logic       ball_release,
    output logic       show_title,
    output logic       show_gameover
);

    import game_flow_controller_pkg::*;

    localparam int unsigned CNT_W = TIMER_W + 1;

    localparam logic [2:0] ST_TITLE     = 3'(TITLE);
    localparam logic [2:0] ST_SERVE     = 3'(SERVE);
    localparam logic [2:0] ST_PLAY      = 3'(PLAY);
    localparam logic [2:0] ST_LIFE_LOST = 3'(LIFE_LOST);
    localparam logic [2:0] ST_GAME_OVER = 3'(GAME_OVER);

    logic [STATE_W-1:0] state_n;
    logic [LIVES_W-1:0] lives_n;
    logic [WAVE_W-1:0]  wave_n;
    logic               start_q;
    logic               start_edge_c;
    logic               entry_q;
    logic               timer_done_c;
    logic [TIMER_W:0]   timer_len_c;

    assign start_edge_c = start_btn && !start_q;

    // frame budget of whichever timed state is active
    always_comb begin
        timer_len_c = CNT_W'(GAMEOVER_FRAMES);
        case (state)
            ST_SERVE:     timer_len_c = CNT_W'(SERVE_FRAMES);
            ST_LIFE_LOST: timer_len_c = CNT_W'(LIFE_LOST_FRAMES);
            default:      timer_len_c = CNT_W'(GAMEOVER_FRAMES);
        endcase
    end

    game_flow_controller_frame_timer #(
        .TIMER_W (TIMER_W)
    ) u_frame_timer (
        .pixel_clk (pixel_clk),
        .rst       (rst),
        .clear     (entry_q),
        .fsync     (fsync),
        .n         (timer_len_c),
        .done_c    (timer_done_c)
    );

    // next-state and counter update
    always_comb begin
        state_n = state;
        lives_n = lives;
        wave_n  = wave;
        case (state)
            ST_TITLE: begin
                if (start_edge_c) begin
                    state_n = ST_SERVE;
                    lives_n = LIVES_W'(LIVES_INIT);
                    wave_n  = WAVE_W'(1);
                end
            end
            ST_SERVE: begin
                if (timer_done_c) begin
                    state_n = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (wave_clear) begin
                    state_n = ST_SERVE;
                    if (wave != {WAVE_W{1'b1}}) begin
                        wave_n = wave + WAVE_W'(1);
                    end
                end else if (ball_lost) begin
                    if (lives > LIVES_W'(1)) begin
                        state_n = ST_LIFE_LOST;
                        lives_n = lives - LIVES_W'(1);
                    end else begin
                        state_n = ST_GAME_OVER;
                        lives_n = '0;
                    end
                end
            end
            ST_LIFE_LOST: begin
                if (timer_done_c) begin
                    state_n = ST_SERVE;
                end
            end
            ST_GAME_OVER: begin
                if (timer_done_c) begin
                    state_n = ST_TITLE;
                end
            end
            default: begin
                state_n = ST_TITLE;
            end
        endcase
    end

    // state, counters and registered decodes of the next state
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            state         <= ST_TITLE;
            lives         <= '0;
            wave          <= '0;
            freeze        <= 1'b1;
            rst_objects   <= 1'b0;
            ball_release  <= 1'b0;
            show_title    <= 1'b1;
            show_gameover <= 1'b0;
            start_q       <= 1'b0;
            entry_q       <= 1'b1;
        end else begin
            state         <= state_n;
            lives         <= lives_n;
            wave          <= wave_n;
            freeze        <= (state_n != ST_PLAY);
            rst_objects   <= (state_n == ST_SERVE) && (state != ST_SERVE);
            ball_release  <= (state_n == ST_PLAY) && (state != ST_PLAY);
            show_title    <= (state_n == ST_TITLE);
            show_gameover <= (state_n == ST_GAME_OVER);
            start_q       <= start_btn;
            entry_q       <= (state_n != state);
        end
    end

endmodule

// File: tb/tb_game_flow_controller.sv
// Directed bench for game_flow_controller with hand-computed expectations.
module tb_game_flow_controller;

    logic       pixel_clk;
    logic       rst;
    logic       fsync;
    logic       start_btn;
    logic       ball_lost;
    logic       wave_clear;
    logic [2:0] state;
    logic [3:0] lives;
    logic [7:0] wave;
    logic       freeze;
    logic       rst_objects;
    logic       ball_release;
    logic       show_title;
    logic       show_gameover;

    localparam int S_TITLE = 0, S_SERVE = 1, S_PLAY = 2, S_LIFE_LOST = 3, S_GAME_OVER = 4;

    int n_compared;
    int n_mismatched;
    int n_rst_obj;
    int n_release;
    int n_title_serve;
    logic [2:0] prev_state;

    game_flow_controller dut (
        .pixel_clk     (pixel_clk),
        .rst           (rst),
        .fsync         (fsync),
        .start_btn     (start_btn),
        .ball_lost     (ball_lost),
        .wave_clear    (wave_clear),
        .state         (state),
        .lives         (lives),
        .wave          (wave),
        .freeze        (freeze),
        .rst_objects   (rst_objects),
        .ball_release  (ball_release),
        .show_title    (show_title),
        .show_gameover (show_gameover)
    );

    initial pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    // strobe and transition counters, sampled mid-cycle
    always @(negedge pixel_clk) begin
        if (rst_objects)  n_rst_obj <= n_rst_obj + 1;
        if (ball_release) n_release <= n_release + 1;
        if (prev_state == 3'(S_TITLE) && state == 3'(S_SERVE)) n_title_serve <= n_title_serve + 1;
        prev_state <= state;
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_compared++;
        if (got != exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            fsync = 1'b1;
            tick();
            fsync = 1'b0;
            tick();
        end
    endtask

    // pulse one PLAY input for a cycle, then let the entry cycle pass
    task automatic pulse_lost();
        ball_lost = 1'b1;
        tick();
        ball_lost = 1'b0;
        tick();
    endtask

    task automatic pulse_clear();
        wave_clear = 1'b1;
        tick();
        wave_clear = 1'b0;
        tick();
    endtask

    task automatic press_start();
        start_btn = 1'b1;
        tick();
        start_btn = 1'b0;
        tick();
    endtask

    initial begin
        n_compared = 0; n_mismatched = 0;
        n_rst_obj = 0; n_release = 0; n_title_serve = 0;
        prev_state = 3'(S_TITLE);
        rst = 1'b1; fsync = 1'b0; start_btn = 1'b0; ball_lost = 1'b0; wave_clear = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        check_val("rst_state", int'(state), S_TITLE);
        check_val("rst_lives", int'(lives), 0);
        check_val("rst_wave", int'(wave), 0);
        check_val("rst_freeze", int'(freeze), 1);
        check_val("rst_title", int'(show_title), 1);
        check_val("rst_gameover", int'(show_gameover), 0);

        frames(5);
        check_val("idle_state", int'(state), S_TITLE);
        check_val("idle_rst_obj", n_rst_obj, 0);
        check_val("idle_release", n_release, 0);

        // held button: single edge
        start_btn = 1'b1;
        repeat (10) tick();
        start_btn = 1'b0;
        tick();
        check_val("start_transitions", n_title_serve, 1);
        check_val("start_state", int'(state), S_SERVE);
        check_val("start_lives", int'(lives), 3);
        check_val("start_wave", int'(wave), 1);
        check_val("start_rst_obj", n_rst_obj, 1);
        check_val("serve_title_off", int'(show_title), 0);

        frames(59);
        check_val("serve_59", int'(state), S_SERVE);
        check_val("serve_59_release", n_release, 0);
        frames(1);
        check_val("serve_60", int'(state), S_PLAY);
        check_val("play_release", n_release, 1);
        check_val("play_freeze", int'(freeze), 0);

        pulse_lost();
        check_val("lost3_state", int'(state), S_LIFE_LOST);
        check_val("lost3_lives", int'(lives), 2);
        frames(89);
        check_val("ll_89", int'(state), S_LIFE_LOST);
        frames(1);
        check_val("ll_90", int'(state), S_SERVE);
        check_val("ll_wave", int'(wave), 1);
        check_val("ll_rst_obj", n_rst_obj, 2);
        frames(60);
        check_val("serve2_play", int'(state), S_PLAY);

        pulse_lost();
        check_val("lost2_lives", int'(lives), 1);
        frames(90);
        frames(60);
        check_val("play3_state", int'(state), S_PLAY);

        pulse_lost();
        check_val("go_state", int'(state), S_GAME_OVER);
        check_val("go_lives", int'(lives), 0);
        check_val("go_show", int'(show_gameover), 1);
        check_val("go_freeze", int'(freeze), 1);
        press_start();
        check_val("go_start_ignored", int'(state), S_GAME_OVER);
        frames(179);
        check_val("go_179", int'(state), S_GAME_OVER);
        frames(1);
        check_val("go_180", int'(state), S_TITLE);
        check_val("go_lives_kept", int'(lives), 0);
        check_val("go_wave_kept", int'(wave), 1);
        check_val("go_title_on", int'(show_title), 1);

        // new game, drop to 2 lives, then clear waves up to saturation
        press_start();
        check_val("g2_lives", int'(lives), 3);
        frames(60);
        pulse_lost();
        frames(90);
        frames(60);
        for (int i = 0; i < 254; i++) begin
            pulse_clear();
            frames(60);
        end
        check_val("w255_wave", int'(wave), 255);
        check_val("w255_state", int'(state), S_PLAY);
        check_val("w255_lives", int'(lives), 2);

        wave_clear = 1'b1;
        ball_lost  = 1'b1;
        tick();
        wave_clear = 1'b0;
        ball_lost  = 1'b0;
        tick();
        check_val("both_state", int'(state), S_SERVE);
        check_val("both_wave", int'(wave), 255);
        check_val("both_lives", int'(lives), 2);

        frames(60);
        check_val("pre_rst_play", int'(state), S_PLAY);
        fsync = 1'b1;
        tick();
        fsync = 1'b0;
        rst = 1'b1;
        ball_lost = 1'b1;
        tick();
        rst = 1'b0;
        ball_lost = 1'b0;
        check_val("mid_rst_state", int'(state), S_TITLE);
        check_val("mid_rst_lives", int'(lives), 0);
        check_val("mid_rst_wave", int'(wave), 0);
        check_val("mid_rst_freeze", int'(freeze), 1);
        check_val("mid_rst_rst_obj", int'(rst_objects), 0);
        check_val("mid_rst_release", int'(ball_release), 0);
        check_val("mid_rst_title", int'(show_title), 1);
        check_val("mid_rst_gameover", int'(show_gameover), 0);

        tick();
        pulse_lost();
        pulse_clear();
        check_val("title_lost_state", int'(state), S_TITLE);
        check_val("title_lost_lives", int'(lives), 0);
        check_val("title_lost_wave", int'(wave), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
